// File: rtl/alu8_if.sv
// rtl/alu8_if.sv - operand/opcode/result bundle for the registered 8-bit ALU
interface alu8_if;
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] out;
    logic [3:0] flags;

    modport master (
        output en,
        output a,
        output b,
        output op,
        input  out,
        input  flags
    );

    modport slave (
        input  en,
        input  a,
        input  b,
        input  op,
        output out,
        output flags
    );
endinterface

// File: rtl/alu8.sv
// rtl/alu8.sv - registered 8-bit ALU with C/Z/N/V flags and clock enable
// Optional multiplier on op 2 is built only when ALU_MUL_EN is defined.
module alu8 (
    input  logic   clk,
    input  logic   rst,
    alu8_if.slave  bus
);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_SEQ = 4'd9;
    localparam logic [3:0] OP_SLT = 4'd10;

    logic [8:0] sum9;
    logic [8:0] diff9;
    logic [7:0] res;
    logic       c_flag;
    logic       v_flag;
    logic [3:0] flags_next;
    logic [7:0] out_q;
    logic [3:0] flags_q;

    assign sum9  = {1'b0, bus.a} + {1'b0, bus.b};
    // Bit 8 of the 9-bit difference is the unsigned borrow.
    assign diff9 = {1'b0, bus.a} - {1'b0, bus.b};

`ifdef ALU_MUL_EN
    logic [15:0] prod;
    assign prod = bus.a * bus.b;
`endif

    always_comb begin
        res    = 8'd0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (bus.op)
            OP_ADD: begin
                res    = sum9[7:0];
                c_flag = sum9[8];
                v_flag = (bus.a[7] == bus.b[7]) && (sum9[7] != bus.a[7]);
            end
            OP_SUB: begin
                res    = diff9[7:0];
                c_flag = diff9[8];
                v_flag = (bus.a[7] != bus.b[7]) && (diff9[7] != bus.a[7]);
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
                res    = prod[7:0];
                c_flag = |prod[15:8];
            end
`endif
            OP_AND: res = bus.a & bus.b;
            OP_OR:  res = bus.a | bus.b;
            OP_XOR: res = bus.a ^ bus.b;
            OP_NOT: res = ~bus.a;
            OP_SHL: begin
                res    = {bus.a[6:0], 1'b0};
                c_flag = bus.a[7];
            end
            OP_SHR: begin
                res    = {1'b0, bus.a[7:1]};
                c_flag = bus.a[0];
            end
            OP_SEQ: res = {7'd0, bus.a == bus.b};
            OP_SLT: res = {7'd0, bus.a < bus.b};
            default: res = 8'd0;
        endcase
        flags_next = {v_flag, res[7], res == 8'd0, c_flag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= 8'd0;
            flags_q <= 4'd0;
        end else if (bus.en) begin
            out_q   <= res;
            flags_q <= flags_next;
        end
    end

    assign bus.out   = out_q;
    assign bus.flags = flags_q;

`ifndef ALU_MUL_EN
    logic unused_mul_op;
    assign unused_mul_op = (OP_MUL == 4'd2);
`endif
endmodule

// File: tb/tb_alu8.sv
// tb/tb_alu8.sv - directed and random self-checking bench for alu8
module tb_alu8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    alu8_if bus ();

    alu8 u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Independent golden model: {flags, out}
    function automatic logic [11:0] model(input logic [7:0] x, input logic [7:0] y, input logic [3:0] o);
        int ux, uy, sx, sy, t;
        logic [7:0] r;
        logic c, v;
        ux = int'(x);
        uy = int'(y);
        sx = (ux > 127) ? ux - 256 : ux;
        sy = (uy > 127) ? uy - 256 : uy;
        r = 8'd0;
        c = 1'b0;
        v = 1'b0;
        case (o)
            4'd0: begin
                t = ux + uy;
                r = 8'(t % 256);
                c = (t > 255);
                t = sx + sy;
                v = (t > 127) || (t < -128);
            end
            4'd1: begin
                t = ux - uy;
                r = 8'((t + 256) % 256);
                c = (ux < uy);
                t = sx - sy;
                v = (t > 127) || (t < -128);
            end
`ifdef ALU_MUL_EN
            4'd2: begin
                t = ux * uy;
                r = 8'(t % 256);
                c = (t > 255);
            end
`endif
            4'd3: r = x & y;
            4'd4: r = x | y;
            4'd5: r = x ^ y;
            4'd6: r = ~x;
            4'd7: begin r = 8'((ux * 2) % 256); c = (ux >= 128); end
            4'd8: begin r = 8'(ux / 2); c = (ux % 2 == 1); end
            4'd9: r = (ux == uy) ? 8'd1 : 8'd0;
            4'd10: r = (ux < uy) ? 8'd1 : 8'd0;
            default: r = 8'd0;
        endcase
        return {v, r[7], (r == 8'd0), c, r};
    endfunction

    task automatic apply(input logic [7:0] x, input logic [7:0] y, input logic [3:0] o);
        @(negedge clk);
        bus.en = 1'b1;
        bus.a  = x;
        bus.b  = y;
        bus.op = o;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        apply(8'd10, 8'd20, 4'd0);
        checks++;
        if (bus.out !== 8'd30) begin
            errors++;
            $display("FAIL pre_reset_load out=%0d expected=30", bus.out);
        end
        @(negedge clk);
        bus.a = 8'hA5; bus.b = 8'h3C; bus.op = 4'd4;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out !== 8'd0 || bus.flags !== 4'd0) begin
            errors++;
            $display("FAIL async_reset out=%0h flags=%0h expected out=0 flags=0", bus.out, bus.flags);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out !== 8'd0 || bus.flags !== 4'd0) begin
            errors++;
            $display("FAIL reset_over_en out=%0h flags=%0h expected out=0 flags=0", bus.out, bus.flags);
        end
        @(negedge clk);
        rst = 1'b0;
        apply(8'd10, 8'd20, 4'd0);
        checks++;
        if (bus.out !== 8'd30 || bus.flags !== 4'd0) begin
            errors++;
            $display("FAIL first_after_reset out=%0d flags=%0h expected out=30 flags=0", bus.out, bus.flags);
        end
    endtask

    task automatic test_carry_zero;
        apply(8'd255, 8'd1, 4'd0);
        checks++;
        if (bus.out !== 8'd0 || bus.flags !== 4'b0011) begin
            errors++;
            $display("FAIL add_carry_zero out=%0d flags=%b expected out=0 flags=0011", bus.out, bus.flags);
        end
        apply(8'd127, 8'd1, 4'd0);
        checks++;
        if (bus.out !== 8'd128 || bus.flags !== 4'b1100) begin
            errors++;
            $display("FAIL add_overflow out=%0d flags=%b expected out=128 flags=1100", bus.out, bus.flags);
        end
    endtask

    task automatic test_sub_mul_shift;
        apply(8'd5, 8'd7, 4'd1);
        checks++;
        if (bus.out !== 8'd254 || bus.flags !== 4'b0101) begin
            errors++;
            $display("FAIL sub_borrow out=%0d flags=%b expected out=254 flags=0101", bus.out, bus.flags);
        end
        apply(8'd20, 8'd20, 4'd2);
        checks++;
`ifdef ALU_MUL_EN
        if (bus.out !== 8'd144 || bus.flags !== 4'b0101) begin
            errors++;
            $display("FAIL mul_high out=%0d flags=%b expected out=144 flags=0101", bus.out, bus.flags);
        end
`else
        if (bus.out !== 8'd0 || bus.flags !== 4'b0010) begin
            errors++;
            $display("FAIL mul_disabled out=%0d flags=%b expected out=0 flags=0010", bus.out, bus.flags);
        end
`endif
        apply(8'h81, 8'h00, 4'd7);
        checks++;
        if (bus.out !== 8'h02 || bus.flags !== 4'b0001) begin
            errors++;
            $display("FAIL shl out=%0h flags=%b expected out=02 flags=0001", bus.out, bus.flags);
        end
        apply(8'h81, 8'h00, 4'd8);
        checks++;
        if (bus.out !== 8'h40 || bus.flags !== 4'b0001) begin
            errors++;
            $display("FAIL shr out=%0h flags=%b expected out=40 flags=0001", bus.out, bus.flags);
        end
    endtask

    task automatic test_compare_reserved;
        apply(8'd9, 8'd9, 4'd9);
        checks++;
        if (bus.out !== 8'd1 || bus.flags !== 4'b0000) begin
            errors++;
            $display("FAIL seq out=%0d flags=%b expected out=1 flags=0000", bus.out, bus.flags);
        end
        apply(8'd3, 8'd200, 4'd10);
        checks++;
        if (bus.out !== 8'd1 || bus.flags !== 4'b0000) begin
            errors++;
            $display("FAIL slt out=%0d flags=%b expected out=1 flags=0000", bus.out, bus.flags);
        end
        apply(8'hFF, 8'hFF, 4'd12);
        checks++;
        if (bus.out !== 8'd0 || bus.flags !== 4'b0010) begin
            errors++;
            $display("FAIL reserved out=%0d flags=%b expected out=0 flags=0010", bus.out, bus.flags);
        end
    endtask

    task automatic test_enable_hold;
        apply(8'hF0, 8'h0F, 4'd4);
        checks++;
        if (bus.out !== 8'hFF || bus.flags !== 4'b0100) begin
            errors++;
            $display("FAIL hold_load out=%0h flags=%b expected out=ff flags=0100", bus.out, bus.flags);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.en = 1'b0;
            bus.a  = 8'(i);
            bus.b  = 8'(i + 1);
            bus.op = 4'(i);
            @(posedge clk);
            #1;
            checks++;
            if (bus.out !== 8'hFF || bus.flags !== 4'b0100) begin
                errors++;
                $display("FAIL hold_cycle%0d out=%0h flags=%b expected out=ff flags=0100", i, bus.out, bus.flags);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0]  x, y;
        logic [3:0]  o;
        logic [11:0] exp_v;
        for (int i = 0; i < 200; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            o = 4'($urandom_range(0, 10));
            exp_v = model(x, y, o);
            apply(x, y, o);
            checks++;
            if ({bus.flags, bus.out} !== exp_v) begin
                errors++;
                $display("FAIL random a=%0h b=%0h op=%0d got flags=%b out=%0h expected flags=%b out=%0h",
                         x, y, o, bus.flags, bus.out, exp_v[11:8], exp_v[7:0]);
            end
        end
    endtask

    initial begin
        bus.en = 1'b1;
        bus.a  = 8'h00;
        bus.b  = 8'h00;
        bus.op = 4'd0;
        #2;
        checks++;
        if (bus.out !== 8'd0 || bus.flags !== 4'd0) begin
            errors++;
            $display("FAIL initial_reset out=%0h flags=%0h expected out=0 flags=0", bus.out, bus.flags);
        end
        test_reset();
        test_carry_zero();
        test_sub_mul_shift();
        test_compare_reserved();
        test_enable_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
